// File: rtl/div_unit_param.sv
// Iterative restoring divider, one quotient bit per cycle, any XLEN.
// Optional macro DIV_EARLY_OUT_EN skips leading-zero dividend bits.
module div_unit_param #(
  parameter int XLEN  = 32,
  parameter int SQN_W = 7,
  parameter int TAG_W = 7,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_flush,
  input  logic [SQN_W-1:0] IN_flushSqN,
  input  logic             IN_valid,
  output logic             IN_ready,
  input  logic [1:0]       IN_op,
  input  logic [XLEN-1:0]  IN_srcA,
  input  logic [XLEN-1:0]  IN_srcB,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [RD_W-1:0]  IN_rd,
  output logic             OUT_valid,
  input  logic             OUT_ready,
  output logic [XLEN-1:0]  OUT_result,
  output logic [SQN_W-1:0] OUT_sqN,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [RD_W-1:0]  OUT_rd,
  output logic             OUT_busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;

  logic [XLEN-1:0] a_q, d_q, q_q, res_q;
  logic [XLEN:0]   rem_q;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, is_rem, spec_q;

  function automatic logic killed(
    input logic [SQN_W-1:0] s,
    input logic [SQN_W-1:0] f,
    input logic             fl
  );
    logic [SQN_W-1:0] diff;
    diff = s - f;
    return fl && !diff[SQN_W-1] && (diff != '0);
  endfunction

  logic kill_in, kill_cur, accept;

  assign kill_in  = killed(IN_sqN, IN_flushSqN, IN_flush);
  assign kill_cur = killed(OUT_sqN, IN_flushSqN, IN_flush);
  assign accept   = (state == IDLE) && IN_valid && !kill_in;

  logic            sgn, sign_a, sign_b, div_zero, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;
  logic [CW-1:0]   start_cnt;

  assign sgn      = ~IN_op[0];
  assign sign_a   = sgn & IN_srcA[XLEN-1];
  assign sign_b   = sgn & IN_srcB[XLEN-1];
  assign mag_a    = sign_a ? -IN_srcA : IN_srcA;
  assign mag_b    = sign_b ? -IN_srcB : IN_srcB;
  assign div_zero = (IN_srcB == '0);
  assign ovf      = sgn && (IN_srcA == {1'b1, {(XLEN-1){1'b0}}})
                    && (IN_srcB == '1);
  assign special  = div_zero | ovf;

  // Results for divide-by-zero and signed overflow
  always_comb begin
    spec_val = '0;
    unique case (1'b1)
      div_zero: spec_val = IN_op[1] ? IN_srcA : '1;
      ovf:      spec_val = IN_op[1] ? '0 : IN_srcA;
      default:  spec_val = '0;
    endcase
  end

`ifdef DIV_EARLY_OUT_EN
  // Start at the highest set bit of the dividend magnitude
  always_comb begin
    start_cnt = '0;
    for (int i = 0; i < XLEN; i++)
      if (mag_a[i]) start_cnt = CW'(i);
  end
`else
  assign start_cnt = CW'(XLEN - 1);
`endif

  logic            bit_in, take;
  logic [XLEN+1:0] trial;
  logic [XLEN:0]   rem_n;
  logic [XLEN-1:0] q_n, fin_q, fin_r;

  // One restoring step and the final sign fix-up
  always_comb begin
    bit_in = a_q[cnt];
    trial  = {rem_q, bit_in} - {2'b00, d_q};
    take   = ~trial[XLEN+1];
    rem_n  = take ? trial[XLEN:0] : {rem_q[XLEN-1:0], bit_in};
    q_n      = q_q;
    q_n[cnt] = take;
    fin_q  = neg_q ? -q_n : q_n;
    fin_r  = neg_r ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: begin
        if (kill_cur)                    state_n = IDLE;
        else if (spec_q || cnt == '0)    state_n = DONE;
      end
      DONE: if (kill_cur || OUT_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q        <= mag_a;
      d_q        <= mag_b;
      rem_q      <= '0;
      q_q        <= '0;
      cnt        <= start_cnt;
      neg_q      <= sign_a ^ sign_b;
      neg_r      <= sign_a;
      is_rem     <= IN_op[1];
      spec_q     <= special;
      res_q      <= spec_val;
      OUT_sqN    <= IN_sqN;
      OUT_tagDst <= IN_tagDst;
      OUT_rd     <= IN_rd;
    end else if (state == BUSY && !spec_q) begin
      rem_q <= rem_n;
      q_q   <= q_n;
      cnt   <= cnt - CW'(1);
      if (cnt == '0) res_q <= is_rem ? fin_r : fin_q;
    end
  end

  assign IN_ready   = (state == IDLE);
  assign OUT_valid  = (state == DONE);
  assign OUT_busy   = (state != IDLE);
  assign OUT_result = res_q;

endmodule
